// File: rtl/gf2_poly_div_pkg.sv
// Shared types, widths and helpers for the GF(2) polynomial divider and its neighbours.
package gf_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned DVD_W = 2 * W - 1;
    localparam int unsigned REM_W = W - 1;
    localparam int unsigned DEG_W = $clog2(W);
    localparam int unsigned CNT_W = $clog2(DVD_W);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    // Index of the highest set coefficient; 0 for the zero polynomial.
    function automatic logic [DEG_W-1:0] poly_degree(input logic [W-1:0] p);
        poly_degree = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (p[i]) poly_degree = DEG_W'(i);
        end
    endfunction

endpackage

// File: rtl/gf2_poly_div_if.sv
// Dividend/divisor request and quotient/remainder response handshake bundle.
interface gf2_poly_div_if;
    import gf_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DVD_W-1:0] in_dividend;
    logic [W-1:0]     in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [DVD_W-1:0] out_quot;
    logic [REM_W-1:0] out_rem;
    logic             out_err;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_err
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_err
    );

endinterface

// File: rtl/gf2_poly_div_lead_one.sv
// W-bit priority encoder: leading-one index and zero flag of a polynomial.
module gf_lead_one
    import gf_pkg::*;
(
    input  logic [W-1:0]     poly,
    output logic [DEG_W-1:0] lead_c,
    output logic             zero_c
);

    assign lead_c = poly_degree(poly);
    assign zero_c = (poly == '0);

endmodule

// File: rtl/gf2_poly_div.sv
// Sequential GF(2) long divider, one dividend bit per cycle.
// Define GF2_DIV_ZERO_CHECK_EN to short-cut a zero divisor with out_err set.
module gf2_poly_div
    import gf_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    gf2_poly_div_if.slave bus
);

    state_t           state, state_n;
    logic [REM_W-1:0] r, r_n;
    logic [DVD_W-1:0] q, q_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DVD_W-1:0] dvd, dvd_n;
    logic [W-1:0]     dvs, dvs_n;
    logic [DEG_W-1:0] deg, deg_n;
    logic [W-1:0]     r_sh;
    logic             ready_n, valid_n;
    logic [DVD_W-1:0] quot_n;
    logic [REM_W-1:0] rem_n;
    logic [DEG_W-1:0] lead_deg;
    logic             lead_zero;
`ifdef GF2_DIV_ZERO_CHECK_EN
    logic             err, err_n;
`endif

    gf_lead_one u_lead (
        .poly   (bus.in_divisor),
        .lead_c (lead_deg),
        .zero_c (lead_zero)
    );

    // Next-state and datapath update.
    always_comb begin
        state_n = state;
        r_n     = r;
        q_n     = q;
        cnt_n   = cnt;
        dvd_n   = dvd;
        dvs_n   = dvs;
        deg_n   = deg;
        valid_n = bus.out_valid;
        quot_n  = bus.out_quot;
        rem_n   = bus.out_rem;
`ifdef GF2_DIV_ZERO_CHECK_EN
        err_n   = err;
`endif
        r_sh    = {r, dvd[cnt]};

        case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    // A zero divisor divides a zeroed dividend, so Q and R stay 0.
                    dvd_n   = lead_zero ? '0 : bus.in_dividend;
                    dvs_n   = bus.in_divisor;
                    deg_n   = lead_deg;
                    r_n     = '0;
                    q_n     = '0;
                    cnt_n   = CNT_W'(DVD_W - 1);
                    state_n = DIV;
`ifdef GF2_DIV_ZERO_CHECK_EN
                    err_n   = lead_zero;
                    if (lead_zero) begin
                        state_n = DONE;
                        valid_n = 1'b1;
                        quot_n  = '0;
                        rem_n   = '0;
                    end
`endif
                end
            end
            DIV: begin
                if (r_sh[deg]) begin
                    r_sh     = r_sh ^ dvs;
                    q_n[cnt] = 1'b1;
                end
                r_n = r_sh[REM_W-1:0];
                if (cnt == '0) begin
                    state_n = DONE;
                    valid_n = 1'b1;
                    quot_n  = q_n;
                    rem_n   = r_sh[REM_W-1:0];
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            r             <= '0;
            q             <= '0;
            cnt           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            deg           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_quot  <= '0;
            bus.out_rem   <= '0;
`ifdef GF2_DIV_ZERO_CHECK_EN
            err           <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            r             <= r_n;
            q             <= q_n;
            cnt           <= cnt_n;
            dvd           <= dvd_n;
            dvs           <= dvs_n;
            deg           <= deg_n;
            bus.in_ready  <= ready_n;
            bus.out_valid <= valid_n;
            bus.out_quot  <= quot_n;
            bus.out_rem   <= rem_n;
`ifdef GF2_DIV_ZERO_CHECK_EN
            err           <= err_n;
`endif
        end
    end

`ifdef GF2_DIV_ZERO_CHECK_EN
    assign bus.out_err = err;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf2_poly_div.sv
// Randomised and directed checks of gf2_poly_div against a textbook long-division model.
module tb_gf2_poly_div;
    import gf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf2_poly_div_if bus ();

    gf2_poly_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

`ifdef GF2_DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    // Reference: reduce the dividend by shifted copies of the divisor, highest term first.
    task automatic model(input logic [6:0] a, input logic [3:0] b,
                         output logic [6:0] q, output logic [2:0] r,
                         output logic e, output int lat);
        logic [6:0] rem;
        int dg;
        rem = a;
        q   = '0;
        dg  = 0;
        e   = 1'b0;
        lat = 7;
        if (b == 4'd0) begin
            rem = '0;
            e   = ZCHK;
            lat = ZCHK ? 1 : 7;
        end else begin
            for (int i = 0; i < 4; i++) if (b[i]) dg = i;
            for (int i = 6; i >= dg; i--) begin
                if (rem[i]) begin
                    rem = rem ^ (7'(b) << (i - dg));
                    q[i - dg] = 1'b1;
                end
            end
        end
        r = rem[2:0];
    endtask

    // Present one job, wait for acceptance, then count cycles until out_valid.
    task automatic issue(input logic [6:0] a, input logic [3:0] b, output int waits, output int lat);
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_valid    = 1'b1;
        waits = 0;
        while (!bus.in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.in_dividend = 7'($urandom);
        bus.in_divisor  = 4'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_quot !== 7'd0
            || bus.out_rem !== 3'd0 || bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b q=%b r=%b e=%b, required 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_quot, bus.out_rem, bus.out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic run_checked(input string name, input logic [6:0] a, input logic [3:0] b);
        logic [6:0] eq;
        logic [2:0] er;
        logic ee;
        int el, w, lat;
        model(a, b, eq, er, ee, el);
        issue(a, b, w, lat);
        n_tests++;
        if (lat !== el || bus.out_quot !== eq || bus.out_rem !== er || bus.out_err !== ee) begin
            n_fail++;
            $display("FAIL %s a=%b b=%b: lat=%0d q=%b r=%b e=%b, required lat=%0d q=%b r=%b e=%b",
                     name, a, b, lat, bus.out_quot, bus.out_rem, bus.out_err, el, eq, er, ee);
        end
        release_out();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b, required 1 0",
                     name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [6:0] dv [3] = '{7'b0111010, 7'b1000000, 7'b1010101};
        logic [3:0] ds [3] = '{4'b0110, 4'b1011, 4'b0001};
        // Spot-check the model itself on the worked examples.
        logic [6:0] eq;
        logic [2:0] er;
        logic ee;
        int el;
        model(7'b1000000, 4'b1011, eq, er, ee, el);
        n_tests++;
        if (eq !== 7'b0001011 || er !== 3'b101) begin
            n_fail++;
            $display("FAIL model_example: q=%b r=%b required 0001011 101", eq, er);
        end
        for (int i = 0; i < 3; i++) run_checked("directed", dv[i], ds[i]);
    endtask

    task automatic test_div_zero();
        run_checked("div_zero", 7'b1101101, 4'b0000);
        run_checked("div_zero_rand", 7'($urandom), 4'b0000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) run_checked("random", 7'($urandom), 4'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [6:0] eq;
        logic [2:0] er;
        logic ee;
        int el, w, lat;
        model(7'b1110011, 4'b1101, eq, er, ee, el);
        issue(7'b1110011, 4'b1101, w, lat);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_quot !== eq || bus.out_rem !== er || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: vld=%b q=%b r=%b rdy=%b, required 1 %b %b 0",
                         c, bus.out_valid, bus.out_quot, bus.out_rem, bus.in_ready, eq, er);
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: in_ready=%b required 1", bus.in_ready);
        end
        model(7'b0101110, 4'b0111, eq, er, ee, el);
        issue(7'b0101110, 4'b0111, w, lat);
        n_tests++;
        if (w !== 0 || lat !== el || bus.out_quot !== eq || bus.out_rem !== er) begin
            n_fail++;
            $display("FAIL back_to_back: waits=%0d lat=%0d q=%b r=%b, required 0 %0d %b %b",
                     w, lat, bus.out_quot, bus.out_rem, el, eq, er);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int w;
        bus.in_dividend = 7'b1111111;
        bus.in_divisor  = 4'b1001;
        bus.in_valid    = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_quot !== 7'd0 || bus.out_rem !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid: vld=%b rdy=%b q=%b r=%b, required 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_quot, bus.out_rem);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_idle: vld=%b rdy=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        run_checked("after_reset", 7'b1000000, 4'b1011);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gf2_poly_div.md
# gf2_poly_div

Sequential GF(2) polynomial long divider that undoes the unreduced Karatsuba product. It accepts a (2W−1)-bit carry-less dividend and a W-bit divisor, and returns quotient and remainder. It sits on the output side of the ckm multiplier chain in the Itoh-Tsuji datapath, where it is used for field reduction and for checking products (c / b = a, remainder 0). Processing is one dividend bit per cycle behind a valid/ready handshake.

## Interface
- W, 4, operand width; dividend is 2W−1 bits, divisor W bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_dividend  in  2W−1  carry-less dividend, bit i = coefficient of x^i.
- in_divisor  in  W  divisor polynomial.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_quot  out  2W−1  quotient.
- out_rem  out  W−1  remainder; degree < deg(divisor).
- out_err  out  1  divide-by-zero flag (see Configuration).

## Operation
- States: IDLE → DIV → DONE → IDLE.
- IDLE: in_ready=1. On in_valid: latch the dividend and divisor, and latch d = index of the divisor's leading one. Clear R (W bits), Q, and the bit counter i=2W−2. Go to DIV.
- DIV, each cycle:
  - R' = {R[W−2:0], dividend[i]}.
  - If R'[d]=1: R' ^= divisor and Q[i]=1.
  - Decrement i. After processing i=0, go to DONE.
- DONE: out_valid=1, out_quot=Q, out_rem=R[W−2:0]. On out_ready, go to IDLE.
- All arithmetic is XOR only; no carries. R bits above d are always 0 after each step.
- Divisor 1 (d=0): quotient = dividend, remainder 0.
- Outputs are registered and stable while out_valid=1 and out_ready=0.
- Reset values: in_ready=0 during reset, 1 after the first post-reset edge (IDLE). out_valid=0, out_quot=0, out_rem=0, out_err=0, state=IDLE.
- Reset mid-operation (any state): abandon the operation. The next edge gives IDLE with all outputs at reset values; no partial result appears.

## Timing
- Accept at edge k, when in_valid && in_ready are sampled high.
- DIV occupies edges k+1 … k+2W−1, one dividend bit per edge.
- out_valid is high from edge k+2W−1 (7 cycles for W=4).
- Output handshake at edge m returns the block to IDLE at m. in_ready is high in cycle m+1, so the next accept is at the earliest m+1.
- No overlap between jobs.
- in_dividend and in_divisor are sampled only at the accept edge. Changes while busy are ignored.
- in_valid asserted while busy is held off by in_ready=0; there is no queueing.

## Configuration
- GF2_DIV_ZERO_CHECK_EN defined:
  - A divisor of 0 skips DIV. State goes IDLE → DONE at the accept edge, so out_valid is high at k+1.
  - Result: out_err=1, out_quot=0, out_rem=0.
  - For a non-zero divisor, out_err=0.
- Not defined:
  - out_err is tied 0 and there is no check logic.
  - A divisor of 0 runs the full 2W−1 DIV cycles with no subtraction, giving out_quot=0 and out_rem=0.

## Structure
- Shared package gf_pkg holds:
  - the state enum typedef (IDLE, DIV, DONE);
  - a poly_degree function (leading-one index);
  - localparams for dividend and remainder widths derived from W.
- One sub-module: gf_lead_one, a W-bit priority encoder that produces d and a zero flag. It is reused by the inversion controller.
- Datapath (R, Q, counter) and FSM live in the top module.

## Test plan
- W=4, dividend 7'b0111010, divisor 4'b0110 → out_quot=7'b0001011, out_rem=3'b000, out_valid 7 cycles after accept.
- Dividend 7'b1000000, divisor 4'b1011 → out_quot=7'b0001011, out_rem=3'b101.
- Dividend 7'b1010101, divisor 4'b0001 → out_quot=7'b1010101, out_rem=0.
- Divisor 0:
  - with macro → out_err=1, out_quot=0, out_rem=0, out_valid one cycle after accept;
  - without macro → out_err=0, zero results, 7-cycle latency.
- Hold out_ready=0 for 5 cycles in DONE → outputs constant, in_ready=0. Then out_ready=1 → in_ready=1 in the next cycle, and a back-to-back job is accepted.
- Drive rst_n=0 during the 3rd DIV cycle → next edge gives out_valid=0 and IDLE; after release, a fresh job produces correct results.
